median_frame_reader: RTL and testbench

MEDIAN_FRAME_READER -- requirements
Module: median_frame_reader

---
 rtl/median_pkg.sv | 26 ++
 rtl/median_frame_reader_if.sv | 37 +++
 rtl/med9_lane.sv | 103 ++++++++++
 rtl/median_frame_reader.sv | 163 ++++++++++++++++
 tb/tb_median_frame_reader.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/median_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : median_pkg
//  Purpose  : Shared widths, pipeline depth and FSM state encoding for the
//             nine-frame per-lane median reader.
//  Contents : DATA_W, LANE_W, ADDR_W, NUM_FRAMES, PIPE_LAT, state_t
//  Revision : 1.0  initial release
// ============================================================================
package median_pkg;

  localparam int DATA_W     = 64;
  localparam int LANE_W     = 16;
  localparam int ADDR_W     = 10;
  localparam int NUM_FRAMES = 9;
  // One RAM read cycle followed by three median register stages.
  localparam int PIPE_LAT   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/median_frame_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : median_frame_reader_if
//  Purpose  : Control and output-stream bundle of median_frame_reader.
//  Signals  : start, frame_len          - frame request (master -> slave)
//             busy, done, err_nofill    - status (slave -> master)
//             out_valid, out_data,
//             out_last                  - median word stream (slave -> master)
//  Modports : master (requester / sink), slave (the reader)
//  Revision : 1.0  initial release
// ============================================================================
interface median_frame_reader_if #(
  parameter int DATA_W = median_pkg::DATA_W,
  parameter int ADDR_W = median_pkg::ADDR_W
);

  logic              start;
  logic [ADDR_W-1:0] frame_len;
  logic              busy;
  logic              done;
  logic              err_nofill;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output start, frame_len,
    input  busy, done, err_nofill, out_valid, out_data, out_last
  );

  modport slave (
    input  start, frame_len,
    output busy, done, err_nofill, out_valid, out_data, out_last
  );

endinterface
`default_nettype wire

// File: rtl/med9_lane.sv
`default_nettype none
// ============================================================================
//  Module   : med9_lane
//  Purpose  : Signed median of nine LANE_W samples using the classic
//             19 compare-exchange network, split over three register stages
//             (9 / 6 / 4 compare-exchanges).
//  Ports    : clk, rst  - clock, synchronous active-high reset
//             din       - nine samples, sample k at [k*LANE_W +: LANE_W]
//             med       - registered median, three cycles after din
//  Revision : 1.0  initial release
// ============================================================================
module med9_lane
  import median_pkg::*;
#(
  parameter int LANE_W = median_pkg::LANE_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_FRAMES*LANE_W-1:0] din,
  output logic [LANE_W-1:0]            med
);

  typedef logic signed [LANE_W-1:0] samp_t;

  // Compare-exchange: returns {larger, smaller}.
  function automatic logic [2*LANE_W-1:0] cx(input samp_t a, input samp_t b);
    return (a > b) ? {a, b} : {b, a};
  endfunction

  samp_t w_p1 [NUM_FRAMES];
  samp_t r_s1 [NUM_FRAMES];
  samp_t w_p2 [NUM_FRAMES];
  samp_t r_s2_2, r_s2_4, r_s2_6, r_s2_7;
  samp_t w_q2, w_q4, w_q6, w_q7;
  samp_t r_med;

  // Stage 1: sort each row of three.
  always_comb begin
    for (int k = 0; k < NUM_FRAMES; k++) begin
      w_p1[k] = samp_t'(din[k*LANE_W +: LANE_W]);
    end
    {w_p1[2], w_p1[1]} = cx(w_p1[1], w_p1[2]);
    {w_p1[5], w_p1[4]} = cx(w_p1[4], w_p1[5]);
    {w_p1[8], w_p1[7]} = cx(w_p1[7], w_p1[8]);
    {w_p1[1], w_p1[0]} = cx(w_p1[0], w_p1[1]);
    {w_p1[4], w_p1[3]} = cx(w_p1[3], w_p1[4]);
    {w_p1[7], w_p1[6]} = cx(w_p1[6], w_p1[7]);
    {w_p1[2], w_p1[1]} = cx(w_p1[1], w_p1[2]);
    {w_p1[5], w_p1[4]} = cx(w_p1[4], w_p1[5]);
    {w_p1[8], w_p1[7]} = cx(w_p1[7], w_p1[8]);
  end

  // Stage 2: column ordering; only candidates 2,4,6,7 survive.
  always_comb begin
    for (int k = 0; k < NUM_FRAMES; k++) begin
      w_p2[k] = r_s1[k];
    end
    {w_p2[3], w_p2[0]} = cx(w_p2[0], w_p2[3]);
    {w_p2[8], w_p2[5]} = cx(w_p2[5], w_p2[8]);
    {w_p2[7], w_p2[4]} = cx(w_p2[4], w_p2[7]);
    {w_p2[6], w_p2[3]} = cx(w_p2[3], w_p2[6]);
    {w_p2[4], w_p2[1]} = cx(w_p2[1], w_p2[4]);
    {w_p2[5], w_p2[2]} = cx(w_p2[2], w_p2[5]);
  end

  // Stage 3: diagonal resolution; position 4 ends up holding the median.
  always_comb begin
    w_q2 = r_s2_2;
    w_q4 = r_s2_4;
    w_q6 = r_s2_6;
    w_q7 = r_s2_7;
    {w_q7, w_q4} = cx(w_q4, w_q7);
    {w_q2, w_q4} = cx(w_q4, w_q2);
    {w_q4, w_q6} = cx(w_q6, w_q4);
    {w_q2, w_q4} = cx(w_q4, w_q2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_FRAMES; k++) begin
        r_s1[k] <= '0;
      end
      r_s2_2 <= '0;
      r_s2_4 <= '0;
      r_s2_6 <= '0;
      r_s2_7 <= '0;
      r_med  <= '0;
    end else begin
      for (int k = 0; k < NUM_FRAMES; k++) begin
        r_s1[k] <= w_p1[k];
      end
      r_s2_2 <= w_p2[2];
      r_s2_4 <= w_p2[4];
      r_s2_6 <= w_p2[6];
      r_s2_7 <= w_p2[7];
      r_med  <= w_q4;
    end
  end

  assign med = r_med;

endmodule
`default_nettype wire

// File: rtl/median_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : median_frame_reader
//  Purpose  : Reads one frame from nine frame RAMs in lock-step and emits the
//             per-lane signed median of the nine words at fixed latency.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             fsm_n               - writer slot currently being written
//             rd_addr             - shared read address to all nine RAMs
//             rd_data_1..9        - RAM read data, one cycle after rd_addr
//             bus (slave)         - start/frame_len in; busy/done/err_nofill
//                                   and the out_valid/out_data/out_last stream
//  Revision : 1.0  initial release
// ============================================================================
module median_frame_reader
  import median_pkg::*;
#(
  parameter int DATA_W = median_pkg::DATA_W,
  parameter int LANE_W = median_pkg::LANE_W,
  parameter int ADDR_W = median_pkg::ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            fsm_n,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_W-1:0]     rd_data_1,
  input  logic [DATA_W-1:0]     rd_data_2,
  input  logic [DATA_W-1:0]     rd_data_3,
  input  logic [DATA_W-1:0]     rd_data_4,
  input  logic [DATA_W-1:0]     rd_data_5,
  input  logic [DATA_W-1:0]     rd_data_6,
  input  logic [DATA_W-1:0]     rd_data_7,
  input  logic [DATA_W-1:0]     rd_data_8,
  input  logic [DATA_W-1:0]     rd_data_9,
  median_frame_reader_if.slave  bus
);

  localparam int c_num_lanes = DATA_W / LANE_W;

  state_t                  r_state;
  logic [ADDR_W-1:0]       r_addr;
  logic [ADDR_W-1:0]       r_last_addr;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;
  logic [3:0]              r_fsm_prev;
  logic [NUM_FRAMES-1:0]   r_fill;
  logic [PIPE_LAT-1:0]     r_vld;
  logic [PIPE_LAT-1:0]     r_lst;
  logic                    w_filled;
  logic                    w_issue;
  logic                    w_issue_last;
  logic [DATA_W-1:0]       w_med;

  // Slot fill tracking: a slot counts once the writer has moved onto it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm_prev <= '0;
      r_fill     <= '0;
    end else begin
      r_fsm_prev <= fsm_n;
      if ((fsm_n != r_fsm_prev) && (fsm_n != 4'd0) && (fsm_n <= 4'(NUM_FRAMES))) begin
        r_fill <= r_fill | (NUM_FRAMES'(1) << (fsm_n - 4'd1));
      end
    end
  end

  assign w_filled = &r_fill;

  // Frame sequencer. Frame length is held as its last address so the
  // 2^ADDR_W-1 word case never needs an address beyond the RAM range.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_last_addr <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (!w_filled) begin
              r_err <= 1'b1;
            end else if (bus.frame_len == '0) begin
              r_state <= FIN;
              r_busy  <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_last_addr <= bus.frame_len - 1'b1;
              r_addr      <= '0;
              r_state     <= READ;
              r_busy      <= 1'b1;
            end
          end
        end
        READ: begin
          if (r_addr == r_last_addr) begin
            r_state <= DRAIN;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        DRAIN: begin
          // Leave once the final word is on the output.
          if (r_vld[PIPE_LAT-1] && r_lst[PIPE_LAT-1]) begin
            r_state <= FIN;
            r_done  <= 1'b1;
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Valid/last travel alongside the data: one RAM cycle plus three stages.
  assign w_issue      = (r_state == READ);
  assign w_issue_last = w_issue && (r_addr == r_last_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_lst <= '0;
    end else begin
      r_vld <= {r_vld[PIPE_LAT-2:0], w_issue};
      r_lst <= {r_lst[PIPE_LAT-2:0], w_issue_last};
    end
  end

  for (genvar gi = 0; gi < c_num_lanes; gi++) begin : g_lane
    med9_lane #(
      .LANE_W (LANE_W)
    ) u_med9 (
      .clk (clk),
      .rst (rst),
      .din ({rd_data_9[gi*LANE_W +: LANE_W], rd_data_8[gi*LANE_W +: LANE_W],
             rd_data_7[gi*LANE_W +: LANE_W], rd_data_6[gi*LANE_W +: LANE_W],
             rd_data_5[gi*LANE_W +: LANE_W], rd_data_4[gi*LANE_W +: LANE_W],
             rd_data_3[gi*LANE_W +: LANE_W], rd_data_2[gi*LANE_W +: LANE_W],
             rd_data_1[gi*LANE_W +: LANE_W]}),
      .med (w_med[gi*LANE_W +: LANE_W])
    );
  end

  assign rd_addr        = r_addr;
  assign bus.out_valid  = r_vld[PIPE_LAT-1];
  assign bus.out_last   = r_lst[PIPE_LAT-1];
  assign bus.out_data   = w_med;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err_nofill = r_err;

endmodule
`default_nettype wire

// File: tb/tb_median_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_median_frame_reader
//  Purpose  : Directed self-checking bench for median_frame_reader with a
//             scoreboard queue of expected output words.
//  Revision : 1.0  initial release
// ============================================================================
module tb_median_frame_reader;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  fsm_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data [1:9];
  logic [63:0] mem [9][1024];

  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   beats = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;
  bit   arm_first = 1'b0;

  int mix  [9] = '{-9, -1, 0, 3, -32768, 32767, 5, 2, 1};
  int trip [9] = '{7, 7, 7, 1, 1, 1, 9, 9, 9};

  median_frame_reader_if #(.DATA_W(64), .ADDR_W(10)) bus ();

  median_frame_reader dut (
    .clk       (clk),
    .rst       (rst),
    .fsm_n     (fsm_n),
    .rd_addr   (rd_addr),
    .rd_data_1 (rd_data[1]),
    .rd_data_2 (rd_data[2]),
    .rd_data_3 (rd_data[3]),
    .rd_data_4 (rd_data[4]),
    .rd_data_5 (rd_data[5]),
    .rd_data_6 (rd_data[6]),
    .rd_data_7 (rd_data[7]),
    .rd_data_8 (rd_data[8]),
    .rd_data_9 (rd_data[9]),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Synchronous-read frame RAMs.
  always @(posedge clk) begin
    for (int k = 1; k <= 9; k++) rd_data[k] <= mem[k-1][rd_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every presented word is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        beats++;
        if (arm_first) begin
          first_cyc = cyc;
          arm_first = 1'b0;
        end
        if (bus.out_last === 1'b1) last_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got data %h, expected no beat (cycle %0d)", bus.out_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", bus.out_data, e.data);
          check("beat_last", 64'(bus.out_last), 64'(e.last));
        end
      end
    end
  end

  task automatic pulse_start(input int len);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.frame_len = 10'(len);
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  task automatic step_fsm(input int from, input int to);
    for (int k = from; k <= to; k++) begin
      @(posedge clk); #1;
      fsm_n = 4'(k);
    end
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input logic [63:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Wait for done, then check its timing, the beat count and the drain.
  task automatic finish_frame(input string tag, input int len, input int b0);
    bit found;
    found = 1'b0;
    for (int i = 0; i < len + 100 && !found; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) found = 1'b1;
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_done_timeout: got no done, expected done within %0d cycles", tag, len + 100);
    end else begin
      check({tag, "_done_after_last"}, 64'(cyc - last_cyc), 64'd1);
      check({tag, "_busy_in_fin"}, 64'(bus.busy), 64'd1);
      check({tag, "_rd_addr_hold"}, 64'(rd_addr), 64'(len - 1));
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
      check({tag, "_busy_idle"}, 64'(bus.busy), 64'd0);
    end
    check({tag, "_beat_count"}, 64'(beats - b0), 64'(len));
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int t_cyc;
    bit hit;

    rst = 1'b1;
    fsm_n = 4'd0;
    bus.start = 1'b0;
    bus.frame_len = '0;
    for (int k = 0; k < 9; k++)
      for (int a = 0; a < 1024; a++) mem[k][a] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_err", 64'(bus.err_nofill), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Partial fill: start must be refused
    step_fsm(1, 5);
    b0 = beats;
    pulse_start(8);
    @(negedge clk);
    check("nofill_err_pulse", 64'(bus.err_nofill), 64'd1);
    check("nofill_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("nofill_err_once", 64'(bus.err_nofill), 64'd0);
    check("nofill_busy2", 64'(bus.busy), 64'd0);
    repeat (8) @(negedge clk);
    check("nofill_no_beats", 64'(beats - b0), 64'd0);

    // Complete the fill; frame k holds 10*k in every lane
    step_fsm(6, 9);
    for (int k = 1; k <= 9; k++)
      for (int a = 0; a < 8; a++)
        mem[k-1][a] = {4{16'(10 * k)}};
    for (int a = 0; a < 8; a++) push_exp(64'h0032_0032_0032_0032, a == 7);
    b0 = beats;
    arm_first = 1'b1;
    pulse_start(8);
    @(negedge clk);
    t_cyc = cyc;
    check("f8_rd_addr0", 64'(rd_addr), 64'd0);
    finish_frame("f8", 8, b0);
    check("f8_latency", 64'(first_cyc - t_cyc), 64'd4);

    // Signed mix, rotated per address; plus ignored restart and fsm_n churn
    for (int k = 1; k <= 9; k++)
      for (int a = 0; a < 4; a++)
        mem[k-1][a] = {16'(trip[(k - 1 + 2 * a) % 9]), 16'(-5), 16'(100 * k), 16'(mix[(k - 1 + a) % 9])};
    for (int a = 0; a < 4; a++) push_exp(64'h0007_FFFB_01F4_0001, a == 3);
    b0 = beats;
    arm_first = 1'b1;
    pulse_start(4);
    @(negedge clk);
    t_cyc = cyc;
    check("mix_rd_addr0", 64'(rd_addr), 64'd0);
    check("mix_busy", 64'(bus.busy), 64'd1);
    bus.start = 1'b1;
    bus.frame_len = 10'd2;
    fsm_n = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    fsm_n = 4'd0;
    finish_frame("mix", 4, b0);
    check("mix_latency", 64'(first_cyc - t_cyc), 64'd4);

    // Zero-length frame
    b0 = beats;
    pulse_start(0);
    @(negedge clk);
    check("len0_busy_fin", 64'(bus.busy), 64'd1);
    check("len0_done", 64'(bus.done), 64'd1);
    check("len0_no_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("len0_busy_idle", 64'(bus.busy), 64'd0);
    check("len0_done_clear", 64'(bus.done), 64'd0);
    repeat (6) @(negedge clk);
    check("len0_no_beats", 64'(beats - b0), 64'd0);

    // Full-depth frame of 1023 words
    for (int k = 1; k <= 9; k++)
      for (int a = 0; a < 1023; a++)
        mem[k-1][a] = {16'(7 * k - 40), 16'(10 * k), 16'(-(k * a)), 16'(k + a)};
    for (int a = 0; a < 1023; a++)
      push_exp({16'(-5), 16'd50, 16'(-5 * a), 16'(5 + a)}, a == 1022);
    b0 = beats;
    pulse_start(1023);
    finish_frame("max", 1023, b0);

    // Reset in the middle of a 16-word frame
    b0 = beats;
    pulse_start(16);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1 && rd_addr == 10'd3) hit = 1'b1;
    end
    if (!hit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL midrst_addr3_timeout: got no rd_addr 3, expected it within 20 cycles");
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out_data", bus.out_data, 64'd0);
    check("midrst_out_last", 64'(bus.out_last), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_err", 64'(bus.err_nofill), 64'd0);
    check("midrst_rd_addr", 64'(rd_addr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_no_beats", 64'(beats - b0), 64'd0);
    pulse_start(8);
    @(negedge clk);
    check("midrst_err_nofill", 64'(bus.err_nofill), 64'd1);
    check("midrst_busy_after", 64'(bus.busy), 64'd0);
    repeat (10) @(negedge clk);
    check("midrst_no_beats2", 64'(beats - b0), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
